// File: rtl/cpu8_pkg.sv
// -----------------------------------------------------------------------------
// cpu8_pkg
//   Shared types and constants for the 8-bit CPU fetch/sequencer slice.
//   - state_t      : sequencer states (IDLE, FETCH, EXEC, HALTED)
//   - PC_W / IR_W  : program counter and instruction register widths
//   - PAGE_W       : width of the page (upper) and offset (lower) PC halves
//   - RESET_PC_DEFAULT : default PC value loaded on reset
// -----------------------------------------------------------------------------
package cpu8_pkg;

  localparam int PC_W   = 16;
  localparam int IR_W   = 16;
  localparam int PAGE_W = 8;

  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

endpackage

// File: rtl/ret_stack.sv
// -----------------------------------------------------------------------------
// ret_stack
//   Small LIFO of return addresses for CALL/RET. Built only when the
//   CPU8_CALL_STACK_EN macro is defined at the top level.
//   Ports:
//     i_clk, i_rst : clock, synchronous active-high reset (empties the stack)
//     i_push, i_din: write i_din on top (ignored when full)
//     i_pop        : discard the top entry (ignored when empty)
//     o_dout       : current top entry (meaningful only when !o_empty)
//     o_full       : DEPTH entries held
//     o_empty      : no entries held
// -----------------------------------------------------------------------------
module ret_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     r_mem [DEPTH];
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_top;

  // Index of the top entry; only used while the stack is non-empty.
  always_comb begin
    w_top = r_cnt - CNT_W'(1);
  end

  assign o_dout  = r_mem[w_top[PTR_W-1:0]];
  assign o_full  = (r_cnt == CNT_W'(DEPTH));
  assign o_empty = (r_cnt == CNT_W'(0));

  // Entry count; push and pop are never asserted together by the sequencer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= CNT_W'(0);
    end else if (i_push && !o_full) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else if (i_pop && !o_empty) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Storage is not reset: contents above the count are never read.
  always_ff @(posedge i_clk) begin
    if (i_push && !o_full) begin
      r_mem[r_cnt[PTR_W-1:0]] <= i_din;
    end
  end

endmodule

// File: rtl/pc_seq.sv
// -----------------------------------------------------------------------------
// pc_seq
//   Program counter and fetch sequencer for the 8-bit CPU.
//   IDLE -> FETCH (req/ack to instruction memory) -> EXEC (wait EXEC_DONE)
//   -> FETCH / IDLE / HALTED. The next PC is formed at EXEC_DONE from the
//   jump decoder results. PC = {page[7:0], offset[7:0]}.
//   Optional feature macro: CPU8_CALL_STACK_EN (adds CALL/RET/STK_ERR and a
//   STACK_DEPTH-entry return stack).
//   Ports:
//     CLK, RST        : clock, synchronous active-high reset
//     RUN             : sequencer advances while high (checked in IDLE, EXEC_DONE)
//     IADDR/IREQ      : fetch address (= PC) and request
//     IACK/IDATA      : fetch acknowledge and same-cycle instruction word
//     PRG/IR_VALID    : instruction register and its live flag (EXEC)
//     JUMP/PAGE/PAGE0/TGT/PGSRC : decoder results for the next PC
//     EXEC_DONE       : datapath finished the current instruction
//     HALT_REQ        : stop after the current instruction
//     PC, HALTED      : program counter, halted flag
//     CALL, RET, STK_ERR (CPU8_CALL_STACK_EN only)
// -----------------------------------------------------------------------------
module pc_seq
  import cpu8_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int              STACK_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RUN,
  output logic [PC_W-1:0]   IADDR,
  output logic              IREQ,
  input  logic              IACK,
  input  logic [IR_W-1:0]   IDATA,
  output logic [IR_W-1:0]   PRG,
  output logic              IR_VALID,
  input  logic              JUMP,
  input  logic              PAGE,
  input  logic              PAGE0,
  input  logic [PAGE_W-1:0] TGT,
  input  logic [PAGE_W-1:0] PGSRC,
  input  logic              EXEC_DONE,
  input  logic              HALT_REQ,
  output logic [PC_W-1:0]   PC,
  output logic              HALTED
`ifdef CPU8_CALL_STACK_EN
  ,
  input  logic              CALL,
  input  logic              RET,
  output logic              STK_ERR
`endif
);

  state_t            r_state;
  state_t            w_state_nx;
  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   w_pc_nx;
  logic [PC_W-1:0]   w_pc_inc;
  logic [PC_W-1:0]   w_pc_jmp;
  logic [PC_W-1:0]   w_pc_sel;
  logic [IR_W-1:0]   r_prg;
  logic              r_ireq;
  logic              r_ir_valid;
  logic              r_halted;
  logic              w_load_ir;
  logic              w_exec_done;

  assign w_exec_done = (r_state == ST_EXEC) && EXEC_DONE;

  // Plain next-PC: sequential increment (16-bit wrap) or decoder jump.
  always_comb begin
    w_pc_inc = r_pc + 16'd1;
    if (JUMP) begin
      if (PAGE) begin
        w_pc_jmp = {(PAGE0 ? 8'h00 : PGSRC), TGT};
      end else begin
        w_pc_jmp = {r_pc[PC_W-1:PAGE_W], TGT};
      end
    end else begin
      w_pc_jmp = w_pc_inc;
    end
  end

`ifdef CPU8_CALL_STACK_EN
  logic            w_push;
  logic            w_pop;
  logic            w_err_set;
  logic            w_stk_full;
  logic            w_stk_empty;
  logic [PC_W-1:0] w_stk_top;
  logic            r_stk_err;

  // Call/return overrides: RET wins over CALL and ignores JUMP; an empty pop
  // falls back to PC+1, a full push still takes the jump.
  always_comb begin
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_err_set = 1'b0;
    w_pc_sel  = w_pc_jmp;
    if (RET) begin
      if (w_stk_empty) begin
        w_pc_sel  = w_pc_inc;
        w_err_set = 1'b1;
      end else begin
        w_pc_sel = w_stk_top;
        w_pop    = 1'b1;
      end
    end else if (CALL && JUMP) begin
      if (w_stk_full) begin
        w_err_set = 1'b1;
      end else begin
        w_push = 1'b1;
      end
    end else begin
      w_pc_sel = w_pc_jmp;
    end
  end

  ret_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (PC_W)
  ) u_ret_stack (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_push  (w_push && w_exec_done),
    .i_pop   (w_pop && w_exec_done),
    .i_din   (w_pc_inc),
    .o_dout  (w_stk_top),
    .o_full  (w_stk_full),
    .o_empty (w_stk_empty)
  );

  // Sticky stack error flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_stk_err <= 1'b0;
    end else if (w_exec_done && w_err_set) begin
      r_stk_err <= 1'b1;
    end else begin
      r_stk_err <= r_stk_err;
    end
  end

  assign STK_ERR = r_stk_err;
`else
  // Without the call stack the decoder jump result is final.
  always_comb begin
    w_pc_sel = w_pc_jmp;
  end
`endif

  // Next-state / PC-update decode.
  always_comb begin
    w_state_nx = r_state;
    w_pc_nx    = r_pc;
    w_load_ir  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (RUN) begin
          w_state_nx = ST_FETCH;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_FETCH: begin
        // Request is held until acknowledged; RUN is not consulted here.
        if (IACK) begin
          w_load_ir  = 1'b1;
          w_state_nx = ST_EXEC;
        end else begin
          w_state_nx = ST_FETCH;
        end
      end
      ST_EXEC: begin
        if (EXEC_DONE) begin
          // PC advances even when halting.
          w_pc_nx = w_pc_sel;
          if (HALT_REQ) begin
            w_state_nx = ST_HALTED;
          end else if (!RUN) begin
            w_state_nx = ST_IDLE;
          end else begin
            w_state_nx = ST_FETCH;
          end
        end else begin
          w_state_nx = ST_EXEC;
        end
      end
      ST_HALTED: begin
        w_state_nx = ST_HALTED;
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  // State, PC, instruction register and registered status outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= ST_IDLE;
      r_pc       <= RESET_PC;
      r_prg      <= 16'h0000;
      r_ireq     <= 1'b0;
      r_ir_valid <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_pc       <= w_pc_nx;
      r_prg      <= w_load_ir ? IDATA : r_prg;
      r_ireq     <= (w_state_nx == ST_FETCH);
      r_ir_valid <= (w_state_nx == ST_EXEC);
      r_halted   <= (w_state_nx == ST_HALTED);
    end
  end

  assign IADDR    = r_pc;
  assign PC       = r_pc;
  assign PRG      = r_prg;
  assign IREQ     = r_ireq;
  assign IR_VALID = r_ir_valid;
  assign HALTED   = r_halted;

endmodule

// File: tb/tb_pc_seq.sv
// -----------------------------------------------------------------------------
// tb_pc_seq
//   Directed bench for pc_seq. Inputs change 1 time unit after the rising
//   edge; outputs are checked at the same point, i.e. away from the edge.
// -----------------------------------------------------------------------------
module tb_pc_seq;

  logic        CLK;
  logic        RST;
  logic        RUN;
  logic [15:0] IADDR;
  logic        IREQ;
  logic        IACK;
  logic [15:0] IDATA;
  logic [15:0] PRG;
  logic        IR_VALID;
  logic        JUMP;
  logic        PAGE;
  logic        PAGE0;
  logic [7:0]  TGT;
  logic [7:0]  PGSRC;
  logic        EXEC_DONE;
  logic        HALT_REQ;
  logic [15:0] PC;
  logic        HALTED;
`ifdef CPU8_CALL_STACK_EN
  logic        CALL;
  logic        RET;
  logic        STK_ERR;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  pc_seq #(
    .RESET_PC    (16'h0000),
    .STACK_DEPTH (4)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RUN       (RUN),
    .IADDR     (IADDR),
    .IREQ      (IREQ),
    .IACK      (IACK),
    .IDATA     (IDATA),
    .PRG       (PRG),
    .IR_VALID  (IR_VALID),
    .JUMP      (JUMP),
    .PAGE      (PAGE),
    .PAGE0     (PAGE0),
    .TGT       (TGT),
    .PGSRC     (PGSRC),
    .EXEC_DONE (EXEC_DONE),
    .HALT_REQ  (HALT_REQ),
    .PC        (PC),
    .HALTED    (HALTED)
`ifdef CPU8_CALL_STACK_EN
    ,
    .CALL      (CALL),
    .RET       (RET),
    .STK_ERR   (STK_ERR)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    RST = 1'b1; RUN = 1'b0; IACK = 1'b0; IDATA = 16'h0000;
    JUMP = 1'b0; PAGE = 1'b0; PAGE0 = 1'b0; TGT = 8'h00; PGSRC = 8'h00;
    EXEC_DONE = 1'b0; HALT_REQ = 1'b0;
`ifdef CPU8_CALL_STACK_EN
    CALL = 1'b0; RET = 1'b0;
`endif
    tick(); tick();

    // Reset state
    check("rst_pc", PC, 16'h0000);
    check("rst_prg", PRG, 16'h0000);
    check("rst_ireq", {15'd0, IREQ}, 16'd0);
    check("rst_irv", {15'd0, IR_VALID}, 16'd0);
    check("rst_halted", {15'd0, HALTED}, 16'd0);

    // Free run: IACK and EXEC_DONE tied high, no jumps
    RST = 1'b0; RUN = 1'b1; IACK = 1'b1; EXEC_DONE = 1'b1; IDATA = 16'hC0DE;
    tick();
    check("run_ireq0", {15'd0, IREQ}, 16'd1);
    check("run_iaddr0", IADDR, 16'h0000);
    tick();
    check("run_prg0", PRG, 16'hC0DE);
    check("run_irv0", {15'd0, IR_VALID}, 16'd1);
    check("run_ireq_exec", {15'd0, IREQ}, 16'd0);
    tick();
    check("run_iaddr1", IADDR, 16'h0001);
    check("run_ireq1", {15'd0, IREQ}, 16'd1);
    tick(); tick();
    check("run_iaddr2", IADDR, 16'h0002);

    // Reach 0x1234 with a paged jump from PGSRC
    JUMP = 1'b1; PAGE = 1'b1; PAGE0 = 1'b0; PGSRC = 8'h12; TGT = 8'h34;
    tick(); tick();
    check("jmp_to_1234", IADDR, 16'h1234);

    // In-page jump
    PAGE = 1'b0; TGT = 8'h80;
    tick(); tick();
    check("jmp_inpage", IADDR, 16'h1280);

    // Paged jump from PGSRC
    PAGE = 1'b1; PAGE0 = 1'b0; PGSRC = 8'h56; TGT = 8'h80;
    tick(); tick();
    check("jmp_pgsrc", IADDR, 16'h5680);

    // Paged jump to page 0
    PAGE0 = 1'b1;
    tick(); tick();
    check("jmp_page0", IADDR, 16'h0080);

    // Delayed acknowledge with changing IDATA
    JUMP = 1'b0; PAGE = 1'b0; PAGE0 = 1'b0; IACK = 1'b0; IDATA = 16'h1111;
    tick();
    check("wait1_ireq", {15'd0, IREQ}, 16'd1);
    check("wait1_iaddr", IADDR, 16'h0080);
    check("wait1_prg", PRG, 16'hC0DE);
    IDATA = 16'h2222;
    tick();
    check("wait2_ireq", {15'd0, IREQ}, 16'd1);
    check("wait2_iaddr", IADDR, 16'h0080);
    IDATA = 16'h3333;
    tick();
    check("wait3_ireq", {15'd0, IREQ}, 16'd1);
    check("wait3_iaddr", IADDR, 16'h0080);
    check("wait3_prg", PRG, 16'hC0DE);
    IACK = 1'b1; IDATA = 16'h4444; EXEC_DONE = 1'b0;
    tick();
    check("ack_prg", PRG, 16'h4444);
    check("ack_irv", {15'd0, IR_VALID}, 16'd1);
    IDATA = 16'h9999;
    tick();
    check("exec_hold_irv", {15'd0, IR_VALID}, 16'd1);
    check("exec_hold_pc", PC, 16'h0080);
    check("exec_hold_prg", PRG, 16'h4444);
    EXEC_DONE = 1'b1;
    tick();
    check("done_pc", IADDR, 16'h0081);
    check("done_irv", {15'd0, IR_VALID}, 16'd0);
    check("done_prg_held", PRG, 16'h4444);

    // 16-bit wrap of PC + 1
    JUMP = 1'b1; PAGE = 1'b1; PAGE0 = 1'b0; PGSRC = 8'hFF; TGT = 8'hFF;
    tick(); tick();
    check("to_ffff", IADDR, 16'hFFFF);
    JUMP = 1'b0;
    tick(); tick();
    check("wrap_0000", IADDR, 16'h0000);

    // Halt after current instruction
    HALT_REQ = 1'b1;
    tick(); tick();
    check("halt_pc", PC, 16'h0001);
    check("halt_flag", {15'd0, HALTED}, 16'd1);
    check("halt_ireq", {15'd0, IREQ}, 16'd0);
    tick(); tick(); tick();
    check("halt_stay_ireq", {15'd0, IREQ}, 16'd0);
    check("halt_stay_flag", {15'd0, HALTED}, 16'd1);
    check("halt_stay_pc", PC, 16'h0001);

    // Reset clears halt
    RST = 1'b1;
    tick();
    check("rst_unhalt", {15'd0, HALTED}, 16'd0);

    // Reset during a fetch with a same-cycle acknowledge
    RST = 1'b0; HALT_REQ = 1'b0; IDATA = 16'h5A5A;
    tick(); tick();
    check("pre_rst_prg", PRG, 16'h5A5A);
    tick();
    check("pre_rst_ireq", {15'd0, IREQ}, 16'd1);
    check("pre_rst_pc", PC, 16'h0001);
    RST = 1'b1; IDATA = 16'hBEEF;
    tick();
    check("rst_fetch_prg", PRG, 16'h0000);
    check("rst_fetch_pc", PC, 16'h0000);
    check("rst_fetch_ireq", {15'd0, IREQ}, 16'd0);
    check("rst_fetch_irv", {15'd0, IR_VALID}, 16'd0);

    // RUN low keeps the sequencer idle
    RST = 1'b0; RUN = 1'b0;
    tick(); tick();
    check("idle_ireq", {15'd0, IREQ}, 16'd0);

`ifdef CPU8_CALL_STACK_EN
    // Get to 0x0010
    RUN = 1'b1; JUMP = 1'b1; PAGE = 1'b1; PAGE0 = 1'b1; TGT = 8'h10;
    tick(); tick(); tick();
    check("stk_at_0010", IADDR, 16'h0010);
    // CALL + JUMP pushes 0x0011
    CALL = 1'b1; PAGE = 1'b0; TGT = 8'h40;
    tick(); tick();
    check("stk_call", IADDR, 16'h0040);
    check("stk_err0", {15'd0, STK_ERR}, 16'd0);
    // RET returns to 0x0011, JUMP ignored
    CALL = 1'b0; RET = 1'b1;
    tick(); tick();
    check("stk_ret", IADDR, 16'h0011);
    // Five nested calls: fifth overflows but still jumps
    RET = 1'b0; CALL = 1'b1;
    for (int k = 0; k < 5; k++) begin
      TGT = 8'h20 + 8'(k);
      tick(); tick();
      check("stk_nest_pc", IADDR, {8'h00, 8'h20 + 8'(k)});
      check("stk_nest_err", {15'd0, STK_ERR}, (k == 4) ? 16'd1 : 16'd0);
    end
    // Top entry is the return address of the 4th call (made at 0x0022)
    CALL = 1'b0; RET = 1'b1;
    tick(); tick();
    check("stk_ret_top", IADDR, 16'h0023);
    RET = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
